sentry_ahb_sub_regs: RTL

- AHB-Lite subordinate (responder) holding the sentry security control/status register file.
- Sits on the system interconnect opposite the sentry AHB controller port, and decodes address/data phases.
- Inserts configurable wait states and returns two-cycle ERROR responses for illegal accesses.
- Drives secure-boot-done and lock status into the security peripheral logic.

---
 rtl/sentry_ahb_sub_regs_pkg.sv | 27 ++
 rtl/sentry_ahb_sub_regs_if.sv | 30 +++
 rtl/sentry_ahb_sub_regs_bytemask.sv | 26 ++
 rtl/sentry_ahb_sub_regs.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sentry_ahb_sub_regs_pkg.sv
// Shared AHB-Lite encodings, FSM state type and REG0 bit positions for the sentry subordinate.
package sentry_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam int REG0_BOOT_DONE_BIT = 0;
  localparam int REG0_LOCK_BIT      = 1;

endpackage

// File: rtl/sentry_ahb_sub_regs_if.sv
// AHB-Lite bus bundle between the interconnect (master side) and the sentry register subordinate.
interface sentry_ahb_sub_regs_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic              hmastlock;
  logic [3:0]        hprot;
  logic              hnonsec;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hmastlock, hprot, hnonsec, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hmastlock, hprot, hnonsec, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/sentry_ahb_sub_regs_bytemask.sv
// Combinational byte-lane enables (little-endian) and alignment check from hsize/haddr[1:0].
module sentry_ahb_sub_bytemask
  import sentry_ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       misaligned
);
  always_comb begin
    be         = 4'b0000;
    misaligned = 1'b0;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      HSIZE_WORD: begin
        be         = 4'b1111;
        misaligned = |addr_lo;
      end
      default: be = 4'b0000;
    endcase
  end
endmodule

// File: rtl/sentry_ahb_sub_regs.sv
// Sentry security register file on AHB-Lite; OKAY completes 1+WAIT_STATES cycles after the address phase, stalling via hreadyout.
// Define SENTRY_AHB_SUB_ERRLOG_EN to add read-only ERRADDR/ERRCNT at word indices NUM_REGS and NUM_REGS+1.
module sentry_ahb_sub_regs
  import sentry_ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 0,
  parameter int SECURE_ONLY = 1
) (
  input  logic                  clk_in,
  input  logic                  rst,
  sentry_ahb_sub_regs_if.slave  bus,
  output logic                  O_sysctl_secure_boot_done,
  output logic                  O_sysctl_lock
);
`ifdef SENTRY_AHB_SUB_ERRLOG_EN
  localparam int TOT_REGS = NUM_REGS + 2;
`else
  localparam int TOT_REGS = NUM_REGS;
`endif
  localparam int RIDX_W = $clog2(NUM_REGS);
  localparam int IDX_W  = RIDX_W + 1;
  localparam logic [ADDR_W-3:0] TOT_A = (ADDR_W-2)'(TOT_REGS);
  localparam logic [IDX_W-1:0]  NUM_I = IDX_W'(NUM_REGS);
  localparam logic [2:0]        WS_M1 = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t            state;
  logic [2:0]        wcnt;
  logic              ph_write;
  logic [IDX_W-1:0]  ph_idx;
  logic [3:0]        ph_be;
  logic [3:0]        acc_be;
  logic              acc_misaligned;
  logic              accept;
  logic              acc_err;
  logic              commit;
  logic              lock_eff;
  logic              ro_err;
  logic [ADDR_W-3:0] waddr;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rd_word;
  logic              unused_ok;

  sentry_ahb_sub_bytemask u_bytemask (
    .size       (bus.hsize),
    .addr_lo    (bus.haddr[1:0]),
    .be         (acc_be),
    .misaligned (acc_misaligned)
  );

  assign waddr  = bus.haddr[ADDR_W-1:2];
  assign accept = bus.hsel & bus.htrans[1] & bus.hready & bus.hreadyout;
  assign commit = (state == ST_DONE) & ph_write;

  // A lock being set by the write now completing must already block the transfer decoded alongside it.
  assign lock_eff = regs[0][REG0_LOCK_BIT]
                  | (commit & (ph_idx == '0) & ph_be[0] & bus.hwdata[REG0_LOCK_BIT]);

  assign acc_err = (bus.hsize > HSIZE_WORD) | acc_misaligned | (waddr >= TOT_A) | ro_err
                 | ((SECURE_ONLY != 0) & bus.hnonsec) | (bus.hwrite & lock_eff);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state         <= ST_IDLE;
      bus.hreadyout <= 1'b1;
      bus.hresp     <= HRESP_OKAY;
      wcnt          <= 3'd0;
      ph_write      <= 1'b0;
      ph_idx        <= '0;
      ph_be         <= 4'b0000;
    end else begin
      unique case (state)
        ST_WAIT: begin
          if (wcnt == 3'd0) begin
            state         <= ST_DONE;
            bus.hreadyout <= 1'b1;
          end else begin
            wcnt <= wcnt - 3'd1;
          end
        end
        ST_ERR1: begin
          state         <= ST_ERR2;
          bus.hreadyout <= 1'b1;
          bus.hresp     <= HRESP_ERROR;
        end
        default: begin
          bus.hresp <= HRESP_OKAY;
          if (accept) begin
            ph_write <= bus.hwrite;
            ph_idx   <= waddr[IDX_W-1:0];
            ph_be    <= acc_be;
            if (acc_err) begin
              state         <= ST_ERR1;
              bus.hreadyout <= 1'b0;
              bus.hresp     <= HRESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              state         <= ST_WAIT;
              bus.hreadyout <= 1'b0;
              wcnt          <= WS_M1;
            end else begin
              state         <= ST_DONE;
              bus.hreadyout <= 1'b1;
            end
          end else begin
            state         <= ST_IDLE;
            bus.hreadyout <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit) begin
      if (ph_idx == '0) begin
        if (ph_be[0]) begin
          regs[0][REG0_BOOT_DONE_BIT] <= bus.hwdata[REG0_BOOT_DONE_BIT];
          regs[0][REG0_LOCK_BIT]      <= regs[0][REG0_LOCK_BIT] | bus.hwdata[REG0_LOCK_BIT];
        end
      end else if (ph_idx < NUM_I) begin
        for (int b = 0; b < 4; b++) begin
          if (ph_be[b]) regs[ph_idx[RIDX_W-1:0]][8*b +: 8] <= bus.hwdata[8*b +: 8];
        end
      end
    end
  end

`ifdef SENTRY_AHB_SUB_ERRLOG_EN
  localparam logic [ADDR_W-3:0] NUM_A = (ADDR_W-2)'(NUM_REGS);
  localparam logic [IDX_W-1:0]  CNT_I = IDX_W'(NUM_REGS + 1);
  logic [ADDR_W-1:0] ph_addr;
  logic [ADDR_W-1:0] erraddr;
  logic [7:0]        errcnt;

  assign ro_err = bus.hwrite & (waddr >= NUM_A);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      ph_addr <= '0;
      erraddr <= '0;
      errcnt  <= 8'd0;
    end else begin
      if (accept) ph_addr <= bus.haddr;
      if (state == ST_ERR1) begin
        erraddr <= ph_addr;
        if (errcnt != 8'hFF) errcnt <= errcnt + 8'd1;
      end
    end
  end
`else
  assign ro_err = 1'b0;
`endif

  always_comb begin
    rd_word = '0;
    if (ph_idx == '0) rd_word[1:0] = regs[0][1:0];
    else if (ph_idx < NUM_I) rd_word = regs[ph_idx[RIDX_W-1:0]];
`ifdef SENTRY_AHB_SUB_ERRLOG_EN
    else if (ph_idx == NUM_I) rd_word = DATA_W'(erraddr);
    else if (ph_idx == CNT_I) rd_word[7:0] = errcnt;
`endif
  end

  assign bus.hrdata = (state == ST_DONE && !ph_write) ? rd_word : '0;

  assign O_sysctl_secure_boot_done = regs[0][REG0_BOOT_DONE_BIT];
  assign O_sysctl_lock             = regs[0][REG0_LOCK_BIT];

  assign unused_ok = ^{bus.hburst, bus.hmastlock, bus.hprot};
endmodule
